react_stats: RTL

Per-player reaction-time bookkeeping stage that sits directly upstream of the RGB indicator block and the COMPARE logic. It tracks the main controller's `machine_state` and `cur_player`, latches one reaction-time sample per trial, and counts the trial index (0..7) per player. After the eighth trial it produces a rounded 10-bit average. Its `test_turn_A/B` and `avr_react_time_A/B` outputs feed the RGB block and the result display directly.

---
 rtl/react_stats_if.sv | 34 +++
 rtl/react_stats.sv | 93 +++++++++
 2 files changed

// File: rtl/react_stats_if.sv
`default_nettype none
// ============================================================================
// Module   : react_stats_if
// Function : Controller-side inputs and per-player statistics outputs of
//            react_stats, bundled for the reaction-time game datapath.
// Revision : 1.0
// ============================================================================
interface react_stats_if #(
    parameter int TW = 10
);
    logic [2:0]    machine_state;
    logic          cur_player;
    logic [TW-1:0] react_time;
    logic [2:0]    test_turn_A;
    logic [2:0]    test_turn_B;
    logic [TW-1:0] avr_react_time_A;
    logic [TW-1:0] avr_react_time_B;
    logic          avr_valid_A;
    logic          avr_valid_B;
    logic [TW-1:0] last_time;

    modport master (
        output machine_state, cur_player, react_time,
        input  test_turn_A, test_turn_B, avr_react_time_A, avr_react_time_B,
               avr_valid_A, avr_valid_B, last_time
    );

    modport slave (
        input  machine_state, cur_player, react_time,
        output test_turn_A, test_turn_B, avr_react_time_A, avr_react_time_B,
               avr_valid_A, avr_valid_B, last_time
    );
endinterface
`default_nettype wire

// File: rtl/react_stats.sv
`default_nettype none
// ============================================================================
// Module   : react_stats
// Function : Per-player reaction-time accumulation, trial counting and
//            rounded eight-sample average, driven by controller state entries.
// Revision : 1.0
// ============================================================================
module react_stats #(
    parameter int TURNS_LOG2 = 3,
    parameter int TW         = 10
) (
    input wire           clk,
    input wire           rst,
    react_stats_if.slave bus
);
    localparam int SW = TW + TURNS_LOG2;

    localparam logic [2:0]            c_IDLE      = 3'd0;
    localparam logic [2:0]            c_STORAGE   = 3'd4;
    localparam logic [2:0]            c_AVERAGE   = 3'd6;
    localparam logic [TURNS_LOG2-1:0] c_LAST_TURN = '1;
    localparam logic [SW-1:0]         c_HALF      = SW'(2 ** (TURNS_LOG2 - 1));

    // Index 1 holds player A, index 0 player B, matching cur_player.
    logic [2:0]            r_prev_state;
    logic                  r_armed;
    logic [SW-1:0]         r_sum   [2];
    logic [TURNS_LOG2-1:0] r_turn  [2];
    logic [TW-1:0]         r_avr   [2];
    logic [1:0]            r_valid;
    logic [TW-1:0]         r_last;

    logic                  w_entry_idle;
    logic                  w_entry_store;
    logic                  w_entry_avg;
    logic                  w_p;
    logic [SW-1:0]         w_sum_rnd;
    logic [TW-1:0]         w_avg;

    // r_armed blocks the first cycle after reset so a state already active at
    // release is absorbed into r_prev_state instead of firing as an entry.
    assign w_entry_idle  = r_armed && (bus.machine_state == c_IDLE)    && (r_prev_state != c_IDLE);
    assign w_entry_store = r_armed && (bus.machine_state == c_STORAGE) && (r_prev_state != c_STORAGE);
    assign w_entry_avg   = r_armed && (bus.machine_state == c_AVERAGE) && (r_prev_state != c_AVERAGE);
    assign w_p           = bus.cur_player;
    assign w_sum_rnd     = r_sum[w_p] + c_HALF;
    assign w_avg         = w_sum_rnd[SW-1:TURNS_LOG2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_state <= c_IDLE;
            r_armed      <= 1'b0;
            r_valid      <= '0;
            r_last       <= '0;
            for (int i = 0; i < 2; i++) begin
                r_sum[i]  <= '0;
                r_turn[i] <= '0;
                r_avr[i]  <= '0;
            end
        end else begin
            r_prev_state <= bus.machine_state;
            r_armed      <= 1'b1;
            if (w_entry_idle) begin
                r_valid <= '0;
                r_last  <= '0;
                for (int i = 0; i < 2; i++) begin
                    r_sum[i]  <= '0;
                    r_turn[i] <= '0;
                    r_avr[i]  <= '0;
                end
            end else if (w_entry_store && !r_valid[w_p]) begin
                r_sum[w_p] <= r_sum[w_p] + SW'(bus.react_time);
                r_last     <= bus.react_time;
            end else if (w_entry_avg && !r_valid[w_p]) begin
                if (r_turn[w_p] == c_LAST_TURN) begin
                    r_avr[w_p]   <= w_avg;
                    r_valid[w_p] <= 1'b1;
                end else begin
                    r_turn[w_p] <= r_turn[w_p] + 1'b1;
                end
            end
        end
    end

    assign bus.test_turn_A      = 3'(r_turn[1]);
    assign bus.test_turn_B      = 3'(r_turn[0]);
    assign bus.avr_react_time_A = r_avr[1];
    assign bus.avr_react_time_B = r_avr[0];
    assign bus.avr_valid_A      = r_valid[1];
    assign bus.avr_valid_B      = r_valid[0];
    assign bus.last_time        = r_last;
endmodule
`default_nettype wire
